// File: rtl/mdu_param.sv
// Parameterised multiply/divide unit with HI/LO registers and a busy/abort handshake.
// Define MDU_MADD_EN to enable the madd/maddu/msub/msubu accumulate ops (8..11).
module mdu_param #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] D1,
  input  logic [WIDTH-1:0] D2,
  input  logic [3:0]       MDUOp,
  input  logic             abort,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             Busy,
  output logic             Start
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

`ifdef MDU_MADD_EN
  localparam logic MADD_EN = 1'b1;
`else
  localparam logic MADD_EN = 1'b0;
`endif

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd8;
  localparam logic [3:0] OP_MADDU = 4'd9;
  localparam logic [3:0] OP_MSUB  = 4'd10;
  localparam logic [3:0] OP_MSUBU = 4'd11;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] op_a, op_b;
  logic [3:0]       op;

  logic is_mul, is_div, is_acc, is_mt, idle_ok, accept;

  assign is_acc  = MADD_EN && (MDUOp >= OP_MADD) && (MDUOp <= OP_MSUBU);
  assign is_mul  = (MDUOp == OP_MULT) || (MDUOp == OP_MULTU) || is_acc;
  assign is_div  = (MDUOp == OP_DIV) || (MDUOp == OP_DIVU);
  assign is_mt   = (MDUOp == OP_MTHI) || (MDUOp == OP_MTLO);
  assign idle_ok = (state == IDLE) && reset && !abort;
  assign accept  = idle_ok && (is_mul || is_div);
  assign Start   = accept;

  // One 2W-bit multiplier serves both signednesses: signed ops sign-extend operands.
  logic             op_sgn;
  logic [2*WIDTH-1:0] ext_a, ext_b, prod, acc;

  assign op_sgn = (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  assign ext_a  = op_sgn ? {{WIDTH{op_a[WIDTH-1]}}, op_a} : {{WIDTH{1'b0}}, op_a};
  assign ext_b  = op_sgn ? {{WIDTH{op_b[WIDTH-1]}}, op_b} : {{WIDTH{1'b0}}, op_b};
  assign prod   = ext_a * ext_b;
  assign acc    = {HI, LO};

  logic signed [WIDTH-1:0] sa, sb, sq, sr;
  assign sa = op_a;
  assign sb = op_b;
  assign sq = sa / sb;
  assign sr = sa % sb;

  logic [2*WIDTH-1:0] res;
  logic               res_we;

  always_comb begin
    res    = '0;
    res_we = 1'b0;
    case (op)
      OP_MULT, OP_MULTU: begin
        res    = prod;
        res_we = 1'b1;
      end
      OP_DIV: begin
        if (op_b != '0) begin
          res_we = 1'b1;
          // Overflow case: quotient wraps to most-negative with zero remainder.
          if (op_a == MOST_NEG && op_b == {WIDTH{1'b1}})
            res = {{WIDTH{1'b0}}, MOST_NEG};
          else
            res = {sr, sq};
        end
      end
      OP_DIVU: begin
        if (op_b != '0) begin
          res_we = 1'b1;
          res    = {op_a % op_b, op_a / op_b};
        end
      end
      OP_MADD, OP_MADDU: begin
        res    = acc + prod;
        res_we = 1'b1;
      end
      OP_MSUB, OP_MSUBU: begin
        res    = acc - prod;
        res_we = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      Busy  <= 1'b0;
      HI    <= '0;
      LO    <= '0;
      op_a  <= '0;
      op_b  <= '0;
      op    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_a  <= D1;
            op_b  <= D2;
            op    <= MDUOp;
            cnt   <= is_div ? CW'(DIV_LAT) : CW'(MUL_LAT);
            Busy  <= 1'b1;
            state <= RUN;
          end else if (idle_ok && is_mt) begin
            if (MDUOp == OP_MTHI) HI <= D1;
            else                  LO <= D1;
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
            Busy  <= 1'b0;
            cnt   <= '0;
          end else if (cnt == CW'(1)) begin
            if (res_we) {HI, LO} <= res;
            state <= IDLE;
            Busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_param.sv
// Self-checking bench for mdu_param (WIDTH=32, MUL_LAT=5, DIV_LAT=10): vector table,
// hand-written abort/reset/stall sequences and randomized ops against a 64-bit model.
module tb_mdu_param;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] D1 = '0, D2 = '0;
  logic [3:0]  MDUOp = '0;
  logic        abort = 1'b0;
  logic [31:0] HI, LO;
  logic        Busy, Start;

  always #5 clk = ~clk;

  mdu_param #(.WIDTH(32), .MUL_LAT(5), .DIV_LAT(10)) dut (
    .clk(clk), .reset(reset), .D1(D1), .D2(D2), .MDUOp(MDUOp), .abort(abort),
    .HI(HI), .LO(LO), .Busy(Busy), .Start(Start)
  );

`ifdef MDU_MADD_EN
  localparam bit MADD_ON = 1'b1;
`else
  localparam bit MADD_ON = 1'b0;
`endif

  int total = 0;
  int bad   = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, ih, il, eh, el;
    int          lat;
  } vec_t;
  vec_t vt[10];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_hilo(input logic [31:0] h, input logic [31:0] l);
    MDUOp = 4'd5; D1 = h; tick;
    MDUOp = 4'd6; D1 = l; tick;
    MDUOp = 4'd0;
    m_hi = h; m_lo = l;
  endtask

  // Present one op for one cycle, then scramble operands and count busy cycles.
  task automatic run_op(input string nm, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input int lat);
    int n;
    MDUOp = op; D1 = a; D2 = b;
    @(negedge clk);
    check($sformatf("%s start", nm), 64'(Start), 64'(lat != 0));
    tick;
    MDUOp = 4'd0; D1 = $urandom; D2 = $urandom;
    n = 0;
    while (Busy && n < 40) begin
      n++;
      tick;
    end
    check($sformatf("%s busy_cycles", nm), 64'(n), 64'(lat));
    check($sformatf("%s HI", nm), 64'(HI), 64'(eh));
    check($sformatf("%s LO", nm), 64'(LO), 64'(el));
  endtask

  // Reference: plain 64-bit arithmetic on the architectural meaning of each op.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int lat);
    logic signed [31:0] as, bs;
    longint sa, sb, q, r;
    logic [63:0] p, hl;
    as = a; bs = b; sa = as; sb = bs;
    hl = {m_hi, m_lo};
    lat = 0;
    case (op)
      4'd1: begin p = sa * sb; hl = p; lat = 5; end
      4'd2: begin p = 64'(a) * 64'(b); hl = p; lat = 5; end
      4'd3: begin
        lat = 10;
        if (b != 0) begin q = sa / sb; r = sa % sb; hl = {r[31:0], q[31:0]}; end
      end
      4'd4: begin
        lat = 10;
        if (b != 0) hl = {a % b, a / b};
      end
      4'd5: hl[63:32] = a;
      4'd6: hl[31:0]  = a;
      4'd8, 4'd9, 4'd10, 4'd11: if (MADD_ON) begin
        p = (op == 4'd8 || op == 4'd10) ? 64'(sa * sb) : 64'(a) * 64'(b);
        hl = (op <= 4'd9) ? hl + p : hl - p;
        lat = 5;
      end
      default: ;
    endcase
    m_hi = hl[63:32]; m_lo = hl[31:0];
  endtask

  initial begin
    int n, lat;
    logic [3:0] rop;
    logic [31:0] ra, rb;
    logic [3:0] ops[14] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7,
                             4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd15};

    vt[0] = '{4'd1, 32'hFFFFFFFE, 32'd3, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vt[1] = '{4'd3, 32'hFFFFFFF9, 32'd2, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vt[2] = '{4'd4, 32'd7, 32'd0, 32'hAAAA, 32'h5555, 32'hAAAA, 32'h5555, 10};
    vt[3] = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h1, 32'h2, 32'h0, 32'h80000000, 10};
    vt[4] = '{4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0, 32'hFFFFFFFE, 32'h00000001, 5};
    vt[5] = '{4'd4, 32'd100, 32'd7, 32'h0, 32'h0, 32'd2, 32'd14, 5 * 2};
    vt[6] = MADD_ON ? '{4'd9, 32'd1, 32'd1, 32'h0, 32'hFFFFFFFF, 32'h1, 32'h0, 5}
                    : '{4'd9, 32'd1, 32'd1, 32'h0, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 0};
    vt[7] = MADD_ON ? '{4'd10, 32'd2, 32'd3, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFA, 5}
                    : '{4'd10, 32'd2, 32'd3, 32'h0, 32'h0, 32'h0, 32'h0, 0};
    vt[8] = '{4'd7, 32'd9, 32'd9, 32'h11, 32'h22, 32'h11, 32'h22, 0};
    vt[9] = '{4'd3, 32'd7, 32'hFFFFFFFE, 32'h0, 32'h0, 32'd1, 32'hFFFFFFFD, 10};

    // Reset overrides a pending op and abort.
    MDUOp = 4'd1; D1 = 32'd3; D2 = 32'd3; abort = 1'b1;
    tick; tick;
    check("reset HI", 64'(HI), 64'h0);
    check("reset LO", 64'(LO), 64'h0);
    check("reset Busy", 64'(Busy), 64'h0);
    MDUOp = 4'd0; abort = 1'b0; reset = 1'b1;
    tick;

    for (int i = 0; i < 10; i++) begin
      set_hilo(vt[i].ih, vt[i].il);
      run_op($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].eh, vt[i].el, vt[i].lat);
    end

    // mthi while busy is dropped; a new op is taken the cycle Busy falls; mthi then lands.
    set_hilo(32'h0, 32'h0);
    MDUOp = 4'd1; D1 = 32'hFFFFFFFE; D2 = 32'd3; tick;
    MDUOp = 4'd5; D1 = 32'h1234; tick;
    MDUOp = 4'd0;
    n = 0;
    while (Busy && n < 40) begin n++; tick; end
    check("mthi_busy HI", 64'(HI), 64'hFFFFFFFF);
    run_op("b2b", 4'd1, 32'd3, 32'd4, 32'h0, 32'd12, 5);
    MDUOp = 4'd5; D1 = 32'h1234;
    @(negedge clk);
    check("mthi start", 64'(Start), 64'h0);
    tick;
    MDUOp = 4'd0;
    check("mthi HI", 64'(HI), 64'h1234);
    check("mthi Busy", 64'(Busy), 64'h0);

    // Abort at busy cycle 3.
    set_hilo(32'hAA, 32'hBB);
    MDUOp = 4'd2; D1 = 32'h10000; D2 = 32'h10000; tick;
    MDUOp = 4'd0; tick; tick;
    abort = 1'b1; tick; abort = 1'b0;
    check("abort3 Busy", 64'(Busy), 64'h0);
    repeat (8) tick;
    check("abort3 HILO", {HI, LO}, {32'hAA, 32'hBB});

    // Abort on the completion cycle suppresses the write.
    MDUOp = 4'd1; D1 = 32'd5; D2 = 32'd5; tick;
    MDUOp = 4'd0; repeat (4) tick;
    check("abort_last still busy", 64'(Busy), 64'h1);
    abort = 1'b1; tick; abort = 1'b0;
    check("abort_last Busy", 64'(Busy), 64'h0);
    repeat (3) tick;
    check("abort_last HILO", {HI, LO}, {32'hAA, 32'hBB});

    // Abort beats a new op in IDLE.
    MDUOp = 4'd3; D1 = 32'd9; D2 = 32'd3; abort = 1'b1;
    @(negedge clk);
    check("abort_idle Start", 64'(Start), 64'h0);
    tick;
    MDUOp = 4'd0; abort = 1'b0;
    check("abort_idle Busy", 64'(Busy), 64'h0);

    // Reset during divide busy cycle 4.
    set_hilo(32'd5, 32'd6);
    MDUOp = 4'd3; D1 = 32'd100; D2 = 32'd7; tick;
    MDUOp = 4'd0; repeat (3) tick;
    reset = 1'b0; tick; reset = 1'b1;
    check("rst_mid HILO", {HI, LO}, 64'h0);
    check("rst_mid Busy", 64'(Busy), 64'h0);
    repeat (15) tick;
    check("rst_mid later HILO", {HI, LO}, 64'h0);

    // Randomized ops against the model.
    set_hilo(32'h0, 32'h0);
    for (int k = 0; k < 150; k++) begin
      rop = ops[$urandom_range(0, 13)];
      ra = $urandom; rb = $urandom;
      case ($urandom_range(0, 9))
        0: rb = 32'h0;
        1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        2: begin ra = $urandom_range(0, 50); rb = $urandom_range(1, 9); end
        3: rb = 32'hFFFFFFFF;
        default: ;
      endcase
      model(rop, ra, rb, lat);
      run_op($sformatf("rnd%0d op%0d", k, rop), rop, ra, rb, m_hi, m_lo, lat);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end
endmodule
